// File: rtl/serial_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// serial_borrow_subtractor
//   Bit-serial, LSB-first subtractor computing diff = a - b - bin over WIDTH
//   shift cycles plus one result-commit cycle. Serves as a low-area recompute
//   checker for adder results (a == sum - b - cin) or as a standalone
//   multi-cycle subtract unit behind a start/done handshake.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output
//   ovf. Without it the port and its logic are absent.
//
// Handshake: start is sampled on a rising edge only while the unit can accept
//   (IDLE, or the final DONE cycle for back-to-back operation); a start seen
//   in SHIFT is dropped, not queued. busy is high in SHIFT and DONE. done is a
//   one-cycle pulse coinciding with diff/bout (and ovf) taking their new
//   values; those outputs then hold until the next done.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      operation in progress
//   done   out  1      one-cycle result-valid pulse
//   diff   out  WIDTH  result (modulo 2^WIDTH)
//   bout   out  1      borrow-out (1 when a < b + bin, unsigned)
//   ovf    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             d_bit;
  logic             br_next;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // One full-subtractor slice operating on the current LSBs.
  always_comb begin
    d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  // Next-state logic. DONE accepts a new start so results can stream at one
  // per WIDTH+1 cycles.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath. The DONE commit reads res_sr/br before a same-cycle accept
  // reloads them, so back-to-back operation needs no extra staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= (state == DONE);

      if (state == SHIFT) begin
        // Result fills from the MSB side so bit 0 lands at res_sr[0] after
        // WIDTH shifts.
        res_sr <= {d_bit, res_sr[WIDTH-1:1]};
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        br     <= br_next;
        cnt    <= cnt + 1'b1;
      end

      if (state == DONE) begin
        diff <= res_sr;
        bout <= br;
        cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (a_msb ^ b_msb) & (a_msb ^ res_sr[WIDTH-1]);
`endif
      end

      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        br     <= bin;
        res_sr <= '0;
        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_borrow_subtractor
//   Bench for serial_borrow_subtractor (WIDTH=4). A cycle-level behavioural
//   model predicts busy/done/diff/bout(/ovf) from plain arithmetic and the
//   documented handshake timing; one compare process checks every cycle.
//   Directed scenarios add hand-computed literal expectations, followed by a
//   randomized run of 1000 accepted operations.
// ---------------------------------------------------------------------------
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: an operation accepted at edge e0 yields done and its
  // result after edge e0+W+1; busy is high between. A start is taken when
  // idle or on the very edge the current operation finishes.
  // ---------------------------------------------------------------------
  logic [W+1:0] exp_q[$];   // {ovf, bout, diff}
  int           m_cnt;
  logic         e_busy, e_done, e_bout, e_ovf;
  logic [W-1:0] e_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_diff = '0;
      e_bout = 1'b0;
      e_ovf  = 1'b0;
      exp_q.delete();
    end else begin
      logic         can_take;
      logic [W+1:0] ent;
      logic [W:0]   full;
      int           sres;
      can_take = (m_cnt == 0) || (m_cnt == 1);
      e_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          ent    = exp_q.pop_front();
          e_done = 1'b1;
          e_diff = ent[W-1:0];
          e_bout = ent[W];
          e_ovf  = ent[W+1];
        end
      end
      if (start && can_take) begin
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        sres = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ent  = {(sres < -(1 << (W-1))) || (sres > (1 << (W-1)) - 1), full[W], full[W-1:0]};
        exp_q.push_back(ent);
        m_cnt = W + 1;
        n_acc++;
      end
      e_busy = (m_cnt > 0);
    end
  end

  // single compare process, evaluated just after the falling edge
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("diff", diff, e_diff);
      check("bout", bout, e_bout);
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", ovf, e_ovf);
`endif
    end
  end

  // ---------------------------------------------------------------------
  // driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------
  task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    start = 1'b1;
    a     = av;
    b     = bv;
    bin   = bi;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom_range(0, (1 << W) - 1));
    b     = W'($urandom_range(0, (1 << W) - 1));
    bin   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: got timeout expected done within 40 cycles at %0t", $time);
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  int cyc;
  int pulses;
  int guard;
  int acc_target;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // 9 - 4 - 0 = 5
    pulse_start(4'd9, 4'd4, 1'b0);
    check("t1_busy_next", busy, 1);
    wait_done(cyc);
    check("t1_latency", cyc, 5);
    check("t1_diff", diff, 5);
    check("t1_bout", bout, 0);
    check("t1_model_pin", e_diff, 5);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);

    // 3 - 5 = 14 borrow, then 0 - 0 - 1 = 15 borrow back-to-back
    pulse_start(4'd3, 4'd5, 1'b0);
    repeat (4) @(negedge clk);
    pulse_start(4'd0, 4'd0, 1'b1);
    check("t2_done1", done, 1);
    check("t2_diff1", diff, 14);
    check("t2_bout1", bout, 1);
    check("t2_busy_b2b", busy, 1);
    wait_done(cyc);
    check("t2_spacing", cyc, 5);
    check("t2_diff2", diff, 15);
    check("t2_bout2", bout, 1);
    check("t2_model_pin", e_diff, 15);
    repeat (2) @(negedge clk);

    // start 2 cycles into an op is ignored: 7 - 2 - 1 = 4
    pulse_start(4'd7, 4'd2, 1'b1);
    @(negedge clk);
    pulse_start(4'd15, 4'd15, 1'b0);
    wait_done(cyc);
    check("t3_diff", diff, 4);
    check("t3_bout", bout, 0);
    count_done(10, pulses);
    check("t3_extra_done", pulses, 0);

    // reset mid-operation aborts
    pulse_start(4'd12, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_diff", diff, 0);
    check("t4_bout", bout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_done(10, pulses);
    check("t4_no_done", pulses, 0);
    pulse_start(4'd10, 4'd3, 1'b1);
    wait_done(cyc);
    check("t4_latency", cyc, 5);
    check("t4_diff", diff, 6);
    check("t4_bout", bout, 0);

`ifdef SERIAL_SUB_OVF_EN
    @(negedge clk);
    pulse_start(4'd8, 4'd1, 1'b0);
    wait_done(cyc);
    check("t5_diff", diff, 7);
    check("t5_ovf", ovf, 1);
    pulse_start(4'd6, 4'd2, 1'b0);
    wait_done(cyc);
    check("t5b_diff", diff, 4);
    check("t5b_ovf", ovf, 0);
`endif

    // randomized traffic; the compare process checks every cycle
    @(negedge clk);
    acc_target = n_acc + 1000;
    guard = 0;
    while (n_acc < acc_target && guard < 20000) begin
      start = ($urandom_range(0, 3) != 0);
      a     = W'($urandom_range(0, (1 << W) - 1));
      b     = W'($urandom_range(0, (1 << W) - 1));
      bin   = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("rand_ops_accepted", 32'(n_acc >= acc_target), 1);
    repeat (W + 4) @(negedge clk);
    check("rand_queue_drained", exp_q.size(), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
